// File: rtl/gppcu_mc_exec_unit.sv
// rtl/gppcu_mc_exec_unit.sv - SIMD multi-cycle unsigned multiply/divide execute unit
module gppcu_mc_exec_unit #(
    parameter int DBW   = 32,
    parameter int LANES = 4,
    parameter int BPC   = 1
) (
    input  logic                   iACLK,
    input  logic                   inRST,
    input  logic                   iVALID,
    input  logic [1:0]             iOPC,
    input  logic [LANES-1:0]       iCOND_OK,
    input  logic [LANES*DBW-1:0]   iOPA,
    input  logic [LANES*DBW-1:0]   iOPB,
    output logic                   oBUSY,
    output logic                   oDONE,
    output logic [LANES*DBW-1:0]   oQ,
    output logic [LANES-1:0]       oZ
);

    localparam int N  = DBW / BPC;
    localparam int CW = $clog2(N + 1);

    typedef enum logic [1:0] {IDLE, ITER, DONE} state_t;

    state_t                          state, state_nxt;
    logic [CW-1:0]                   cnt;
    logic [1:0]                      opc_q;
    logic [LANES-1:0]                mask_q;
    // a_q: multiplicand (mul) or dividend shifting into quotient (div)
    // b_q: multiplier shifting into product low word (mul) or divisor (div)
    // acc_q: product high word (mul) or partial remainder (div)
    logic [LANES-1:0][DBW-1:0]       a_q, b_q, acc_q;
    logic [LANES-1:0][DBW-1:0]       a_nxt, b_nxt, acc_nxt, res;
    logic [DBW:0]                    sum;
    logic [DBW:0]                    trial;
    logic                            qbit;

    // State register
    always_ff @(posedge iACLK or negedge inRST) begin
        if (!inRST) state <= IDLE;
        else        state <= state_nxt;
    end

    // Next-state logic; dropping iVALID during ITER aborts the op
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (iVALID) state_nxt = ITER;
            ITER: begin
                if (!iVALID)             state_nxt = IDLE;
                else if (cnt == CW'(1))  state_nxt = DONE;
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    assign oBUSY = iVALID & (state != DONE);
    assign oDONE = (state == DONE);

    // BPC iteration steps per lane: right-shift shift-add multiply or restoring divide
    always_comb begin
        a_nxt   = a_q;
        b_nxt   = b_q;
        acc_nxt = acc_q;
        sum     = '0;
        trial   = '0;
        qbit    = 1'b0;
        for (int l = 0; l < LANES; l++) begin
            for (int s = 0; s < BPC; s++) begin
                if (opc_q[1]) begin
                    trial = {acc_nxt[l], a_nxt[l][DBW-1]};
                    qbit  = (trial >= {1'b0, b_nxt[l]});
                    if (qbit) trial = trial - {1'b0, b_nxt[l]};
                    acc_nxt[l] = trial[DBW-1:0];
                    a_nxt[l]   = {a_nxt[l][DBW-2:0], qbit};
                end else begin
                    sum = {1'b0, acc_nxt[l]} + (b_nxt[l][0] ? {1'b0, a_nxt[l]} : '0);
                    acc_nxt[l] = sum[DBW:1];
                    b_nxt[l]   = {sum[0], b_nxt[l][DBW-1:1]};
                end
            end
        end
    end

    // Operand capture on accept, iteration update while in ITER
    always_ff @(posedge iACLK or negedge inRST) begin
        if (!inRST) begin
            cnt    <= '0;
            opc_q  <= '0;
            mask_q <= '0;
            a_q    <= '0;
            b_q    <= '0;
            acc_q  <= '0;
        end else if (state == IDLE && iVALID) begin
            cnt    <= CW'(N);
            opc_q  <= iOPC;
            mask_q <= iCOND_OK;
            a_q    <= iOPA;
            b_q    <= iOPB;
            acc_q  <= '0;
        end else if (state == ITER) begin
            cnt    <= cnt - 1'b1;
            a_q    <= a_nxt;
            b_q    <= b_nxt;
            acc_q  <= acc_nxt;
        end
    end

    // Per-lane result selection from the finished iteration registers
    always_comb begin
        res = '0;
        for (int l = 0; l < LANES; l++) begin
            case (opc_q)
                2'd0:    res[l] = b_q[l];
                2'd1:    res[l] = acc_q[l];
                2'd2:    res[l] = a_q[l];
                default: res[l] = acc_q[l];
            endcase
        end
    end

    // Masked result write-back in DONE
    always_ff @(posedge iACLK or negedge inRST) begin
        if (!inRST) begin
            oQ <= '0;
            oZ <= '0;
        end else if (state == DONE) begin
            for (int l = 0; l < LANES; l++) begin
                if (mask_q[l]) begin
                    oQ[l*DBW +: DBW] <= res[l];
                    oZ[l]            <= (res[l] == '0);
                end
            end
        end
    end

endmodule

// File: tb/tb_gppcu_mc_exec_unit.sv
// tb/tb_gppcu_mc_exec_unit.sv - randomized self-checking bench for gppcu_mc_exec_unit
module tb_gppcu_mc_exec_unit;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [1:0]   valid;
    logic [1:0]   opc;
    logic [3:0]   cond;
    logic [127:0] opa, opb;
    logic         busy1, done1, busy2, done2;
    logic [127:0] q1, q2;
    logic [3:0]   z1, z2;

    int n_checks = 0;
    int n_pass   = 0;

    logic [31:0] exp_q [2][4];
    logic [3:0]  exp_z [2];

    always #5 clk = ~clk;

    gppcu_mc_exec_unit #(.DBW(32), .LANES(4), .BPC(1)) dut (
        .iACLK(clk), .inRST(rst_n), .iVALID(valid[0]), .iOPC(opc), .iCOND_OK(cond),
        .iOPA(opa), .iOPB(opb), .oBUSY(busy1), .oDONE(done1), .oQ(q1), .oZ(z1)
    );

    gppcu_mc_exec_unit #(.DBW(32), .LANES(4), .BPC(2)) dut2 (
        .iACLK(clk), .inRST(rst_n), .iVALID(valid[1]), .iOPC(opc), .iCOND_OK(cond),
        .iOPA(opa), .iOPB(opb), .oBUSY(busy2), .oDONE(done2), .oQ(q2), .oZ(z2)
    );

    function automatic logic [31:0] ref_op(logic [1:0] op, logic [31:0] a, logic [31:0] b);
        logic [63:0] p;
        p = 64'(a) * 64'(b);
        case (op)
            2'd0:    return p[31:0];
            2'd1:    return p[63:32];
            2'd2:    return (b == 0) ? 32'hFFFF_FFFF : a / b;
            default: return (b == 0) ? a : a % b;
        endcase
    endfunction

    function automatic logic get_busy(int d);
        return (d != 0) ? busy2 : busy1;
    endfunction

    function automatic logic get_done(int d);
        return (d != 0) ? done2 : done1;
    endfunction

    function automatic logic [127:0] get_q(int d);
        return (d != 0) ? q2 : q1;
    endfunction

    function automatic logic [3:0] get_z(int d);
        return (d != 0) ? z2 : z1;
    endfunction

    function automatic logic [127:0] rand128();
        return {$urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    function automatic void clear_model();
        for (int d = 0; d < 2; d++) begin
            for (int l = 0; l < 4; l++) exp_q[d][l] = '0;
            exp_z[d] = '0;
        end
    endfunction

    // Issue one op on unit d (called just after a falling edge), follow it to DONE and
    // check latency and the written-back results. b2b keeps iVALID high into the next IDLE.
    task automatic run_op(int d, logic [1:0] op, logic [127:0] a, logic [127:0] b,
                          logic [3:0] m, bit b2b, string tag);
        int          n, c, busy_cnt, done_at;
        logic [31:0] res [4];
        logic [127:0] qv;
        logic [3:0]  zv;
        n = (d != 0) ? 16 : 32;
        for (int l = 0; l < 4; l++) res[l] = ref_op(op, a[l*32 +: 32], b[l*32 +: 32]);
        opc = op; opa = a; opb = b; cond = m; valid[d] = 1'b1;
        #1;
        busy_cnt = get_busy(d) ? 1 : 0;
        done_at  = -1;
        c        = 0;
        while (done_at < 0 && c < 100) begin
            @(negedge clk);
            c++;
            if (get_busy(d)) busy_cnt++;
            if (get_done(d)) done_at = c;
            else begin
                opa = rand128(); opb = rand128(); opc = 2'($urandom); cond = 4'($urandom);
            end
        end
        n_checks++;
        if (done_at !== n + 1) $display("FAIL %s done_cycle got %0d want %0d", tag, done_at, n + 1);
        else n_pass++;
        n_checks++;
        if (busy_cnt !== n + 1) $display("FAIL %s busy_cycles got %0d want %0d", tag, busy_cnt, n + 1);
        else n_pass++;
        for (int l = 0; l < 4; l++) begin
            if (m[l]) begin
                exp_q[d][l] = res[l];
                exp_z[d][l] = (res[l] == 0);
            end
        end
        if (!b2b) valid[d] = 1'b0;
        @(negedge clk);
        n_checks++;
        if (get_done(d) !== 1'b0) $display("FAIL %s done_pulse_width got %b want 0", tag, get_done(d));
        else n_pass++;
        qv = get_q(d);
        zv = get_z(d);
        for (int l = 0; l < 4; l++) begin
            n_checks++;
            if (qv[l*32 +: 32] !== exp_q[d][l])
                $display("FAIL %s q_lane%0d got %h want %h", tag, l, qv[l*32 +: 32], exp_q[d][l]);
            else n_pass++;
        end
        n_checks++;
        if (zv !== exp_z[d]) $display("FAIL %s z got %b want %b", tag, zv, exp_z[d]);
        else n_pass++;
    endtask

    task automatic test_reset();
        #1;
        n_checks++;
        if (q1 !== '0 || z1 !== '0) $display("FAIL reset_outputs got q=%h z=%b want 0", q1, z1);
        else n_pass++;
        n_checks++;
        if (done1 !== 1'b0 || busy1 !== 1'b0) $display("FAIL reset_ctrl got done=%b busy=%b want 0", done1, busy1);
        else n_pass++;
        n_checks++;
        if (q2 !== '0 || z2 !== '0 || done2 !== 1'b0) $display("FAIL reset_bpc2 got q=%h z=%b done=%b want 0", q2, z2, done2);
        else n_pass++;
    endtask

    task automatic test_mullo_basic();
        logic [127:0] a, b;
        a = rand128(); b = rand128();
        a[31:0] = 32'h0001_0003;
        b[31:0] = 32'h0000_0005;
        run_op(0, 2'd0, a, b, 4'hF, 1'b0, "mullo_basic");
        n_checks++;
        if (q1[31:0] !== 32'h0005_000F || z1[0] !== 1'b0)
            $display("FAIL mullo_lane0 got %h z=%b want 0005000f z=0", q1[31:0], z1[0]);
        else n_pass++;
    endtask

    task automatic test_mul_max();
        logic [127:0] ones;
        ones = '1;
        run_op(0, 2'd1, ones, ones, 4'hF, 1'b0, "mulhi_max");
        for (int l = 0; l < 4; l++) begin
            n_checks++;
            if (q1[l*32 +: 32] !== 32'hFFFF_FFFE) $display("FAIL mulhi_max_lane%0d got %h want fffffffe", l, q1[l*32 +: 32]);
            else n_pass++;
        end
        run_op(0, 2'd0, ones, ones, 4'hF, 1'b0, "mullo_max");
        n_checks++;
        if (q1 !== {4{32'h0000_0001}}) $display("FAIL mullo_max got %h want 4x00000001", q1);
        else n_pass++;
    endtask

    task automatic test_div();
        logic [127:0] a, b;
        a = {32'd0, 32'd5, 32'd7, 32'd100};
        b = {32'd3, 32'd0, 32'd100, 32'd7};
        run_op(0, 2'd2, a, b, 4'hF, 1'b0, "divu");
        n_checks++;
        if (q1 !== {32'd0, 32'hFFFF_FFFF, 32'd0, 32'd14} || z1 !== 4'b1010)
            $display("FAIL divu_vector got q=%h z=%b want q=%h z=1010", q1, z1, {32'd0, 32'hFFFF_FFFF, 32'd0, 32'd14});
        else n_pass++;
        run_op(0, 2'd3, a, b, 4'hF, 1'b0, "remu");
        n_checks++;
        if (q1 !== {32'd0, 32'd5, 32'd7, 32'd2} || z1 !== 4'b1000)
            $display("FAIL remu_vector got q=%h z=%b want q=%h z=1000", q1, z1, {32'd0, 32'd5, 32'd7, 32'd2});
        else n_pass++;
    endtask

    task automatic test_mask();
        run_op(0, 2'd0, {4{32'hAAAA_AAAA}}, {4{32'd1}}, 4'hF, 1'b0, "mask_prefill");
        run_op(0, 2'($urandom), rand128(), rand128(), 4'b0101, 1'b0, "mask_0101");
        n_checks++;
        if (q1[63:32] !== 32'hAAAA_AAAA || q1[127:96] !== 32'hAAAA_AAAA)
            $display("FAIL mask_hold got lane1=%h lane3=%h want aaaaaaaa", q1[63:32], q1[127:96]);
        else n_pass++;
    endtask

    task automatic test_zero_mask();
        logic [127:0] q_before;
        logic [3:0]   z_before;
        q_before = q1; z_before = z1;
        run_op(0, 2'd0, rand128(), rand128(), 4'b0000, 1'b0, "zero_mask");
        n_checks++;
        if (q1 !== q_before || z1 !== z_before)
            $display("FAIL zero_mask_hold got q=%h z=%b want q=%h z=%b", q1, z1, q_before, z_before);
        else n_pass++;
    endtask

    task automatic test_flush();
        logic [127:0] q_before;
        q_before = q1;
        opc = 2'd0; opa = rand128(); opb = rand128(); cond = 4'hF; valid[0] = 1'b1;
        repeat (10) @(negedge clk);
        valid[0] = 1'b0;
        @(negedge clk);
        n_checks++;
        if (done1 !== 1'b0 || q1 !== q_before)
            $display("FAIL flush_abort got done=%b q=%h want done=0 q=%h", done1, q1, q_before);
        else n_pass++;
        run_op(0, 2'd2, rand128(), {4{32'd9}}, 4'hF, 1'b0, "after_flush");
    endtask

    task automatic test_back_to_back();
        run_op(0, 2'd0, rand128(), rand128(), 4'hF, 1'b1, "b2b_first");
        run_op(0, 2'd3, rand128(), {32'd0, 32'd13, $urandom(), 32'd1}, 4'hF, 1'b1, "b2b_second");
        run_op(0, 2'd1, rand128(), rand128(), 4'hF, 1'b0, "b2b_third");
    endtask

    task automatic test_random();
        logic [127:0] a, b;
        for (int i = 0; i < 20; i++) begin
            a = rand128(); b = rand128();
            for (int l = 0; l < 4; l++) begin
                case ($urandom_range(0, 3))
                    0:       b[l*32 +: 32] = 32'd0;
                    1:       b[l*32 +: 32] = 32'($urandom_range(1, 15));
                    default: ;
                endcase
                if ($urandom_range(0, 3) == 0) a[l*32 +: 32] = 32'($urandom_range(0, 20));
            end
            run_op(0, 2'($urandom), a, b, 4'($urandom), 1'b0, "random");
        end
    endtask

    task automatic test_bpc2_and_reset();
        run_op(1, 2'd0, rand128(), rand128(), 4'hF, 1'b0, "bpc2_mullo");
        run_op(1, 2'd2, {32'd0, 32'd5, 32'd7, 32'd100}, {32'd3, 32'd0, 32'd100, 32'd7}, 4'hF, 1'b0, "bpc2_divu");
        run_op(1, 2'd1, rand128(), rand128(), 4'b1011, 1'b0, "bpc2_mulhi");
        opc = 2'd3; opa = rand128(); opb = rand128(); cond = 4'hF; valid[1] = 1'b1;
        repeat (5) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        n_checks++;
        if (q2 !== '0 || z2 !== '0 || done2 !== 1'b0)
            $display("FAIL async_reset got q=%h z=%b done=%b want 0", q2, z2, done2);
        else n_pass++;
        n_checks++;
        if (q1 !== '0 || z1 !== '0) $display("FAIL async_reset_unit0 got q=%h z=%b want 0", q1, z1);
        else n_pass++;
        valid[1] = 1'b0;
        #1;
        n_checks++;
        if (busy2 !== 1'b0) $display("FAIL reset_busy got %b want 0", busy2);
        else n_pass++;
        clear_model();
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        run_op(1, 2'd3, rand128(), {32'd0, 32'd3, 32'd17, $urandom()}, 4'hF, 1'b0, "bpc2_after_reset");
    endtask

    initial begin
        rst_n = 1'b0; valid = 2'b00; opc = '0; cond = '0; opa = '0; opb = '0;
        clear_model();
        repeat (3) @(negedge clk);
        test_reset();
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        test_mullo_basic();
        test_mul_max();
        test_div();
        test_mask();
        test_zero_mask();
        test_flush();
        test_back_to_back();
        test_random();
        test_bpc2_and_reset();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
